vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator, successor to the fixed 1024x768 timing block.
- Produces pixel/line counters, sync, blanking, a background colour, line/frame strobes and a frame counter.
- Timing is set by porch/sync/active parameters; a clock-enable allows pixel rates below pclk.
- Sits at the head of the VGA pipeline; all downstream draw stages consume its outputs.

---
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by downstream draw stages.
// Every signal is registered at the source, and the bundle has no backpressure.
interface vga_timing_gen_if #(
    parameter int CNT_W  = 11,
    parameter int FCNT_W = 16
);
    logic [CNT_W-1:0]  hcount_out;
    logic [CNT_W-1:0]  vcount_out;
    logic              hs_out;
    logic              vs_out;
    logic              hblnk_out;
    logic              vblnk_out;
    logic [11:0]       rgb_out;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output hcount_out, vcount_out, hs_out, vs_out, hblnk_out, vblnk_out,
               rgb_out, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  hcount_out, vcount_out, hs_out, vs_out, hblnk_out, vblnk_out,
               rgb_out, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: counters, sync/blank, strobes and a frame counter, all registered.
// Decodes come from the next-count values, so they line up with the counters. en=0 freezes the block and has no backpressure.
module vga_timing_gen #(
    parameter int          H_ACTIVE = 1024,
    parameter int          H_FP     = 24,
    parameter int          H_SYNC   = 136,
    parameter int          H_BP     = 160,
    parameter int          V_ACTIVE = 768,
    parameter int          V_FP     = 3,
    parameter int          V_SYNC   = 6,
    parameter int          V_BP     = 29,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int          CNT_W    = 11,
    parameter logic [11:0] BG_RGB   = 12'h88F,
    parameter int          FCNT_W   = 16
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               en,
    vga_timing_gen_if.master   vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W))) begin : g_cnt_w_too_small
            $fatal(1, "vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0]  hcount_q, hcount_d;
    logic [CNT_W-1:0]  vcount_q, vcount_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              hblnk_q, hblnk_d;
    logic              vblnk_q, vblnk_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0]  h_nxt;
    logic [CNT_W-1:0]  v_nxt;
    logic              h_wrap;
    logic              v_wrap;

    always_comb begin
        h_wrap = (hcount_q == H_LAST);
        v_wrap = (vcount_q == V_LAST);
        h_nxt  = h_wrap ? '0 : hcount_q + 1'b1;
        v_nxt  = vcount_q;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount_q + 1'b1;
        end
    end

    // Strobes default low so they last exactly one cycle, whatever en does next.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        hblnk_d       = hblnk_q;
        vblnk_d       = vblnk_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en) begin
            hcount_d      = h_nxt;
            vcount_d      = v_nxt;
            hblnk_d       = (h_nxt >= H_ACT_C);
            vblnk_d       = (v_nxt >= V_ACT_C);
            hs_d          = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? HS_POL : ~HS_POL;
            vs_d          = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? VS_POL : ~VS_POL;
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vga.hcount_out  = hcount_q;
    assign vga.vcount_out  = vcount_q;
    assign vga.hs_out      = hs_q;
    assign vga.vs_out      = vs_q;
    assign vga.hblnk_out   = hblnk_q;
    assign vga.vblnk_out   = vblnk_q;
    assign vga.rgb_out     = BG_RGB;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using two small-timing instances driven by shared random en/rst.
// The reference model tracks the absolute pixel index since reset and derives every output from it arithmetically.
module tb_vga_timing_gen;
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;

    always #5 pclk = ~pclk;

    vga_timing_gen_if #(.CNT_W(4), .FCNT_W(2)) if_a ();
    vga_timing_gen_if #(.CNT_W(4), .FCNT_W(3)) if_b ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .BG_RGB(12'h88F), .FCNT_W(2)
    ) u_dut_a (
        .pclk (pclk),
        .rst  (rst),
        .en   (en),
        .vga  (if_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(4), .BG_RGB(12'h3C5), .FCNT_W(3)
    ) u_dut_b (
        .pclk (pclk),
        .rst  (rst),
        .en   (en),
        .vga  (if_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model state: pixel index since reset, plus the strobes expected this cycle.
    longint pix = 0;
    bit     exp_ls = 1'b0;
    bit     exp_fs = 1'b0;
    int     ls_seen_a = 0;

    task automatic check_inst(
        input string  pre,
        input int     ha, input int hf, input int hsw, input int hb,
        input int     va, input int vf, input int vsw, input int vb,
        input bit     hpol, input bit vpol, input int fw, input int bg,
        input longint h_o, input longint v_o, input bit hs_o, input bit vs_o,
        input bit     hbl_o, input bit vbl_o, input longint rgb_o,
        input bit     ls_o, input bit fs_o, input longint fc_o
    );
        longint ht, vt, fl, h, v, line;
        bit     e_ls, e_fs;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        fl   = ht * vt;
        h    = pix % ht;
        line = pix / ht;
        v    = line % vt;
        e_ls = 1'b0;
        e_fs = 1'b0;
        if (exp_ls) begin
            e_ls = (pix > 0) && (h == 0);
            e_fs = (pix > 0) && ((pix % fl) == 0);
        end
        chk({pre, ".hcount"}, h_o, h);
        chk({pre, ".vcount"}, v_o, v);
        chk({pre, ".hblnk"}, hbl_o, (h >= ha) ? 1 : 0);
        chk({pre, ".vblnk"}, vbl_o, (v >= va) ? 1 : 0);
        chk({pre, ".hs"}, hs_o, ((h >= ha + hf) && (h < ha + hf + hsw)) ? hpol : !hpol);
        chk({pre, ".vs"}, vs_o, ((v >= va + vf) && (v < va + vf + vsw)) ? vpol : !vpol);
        chk({pre, ".rgb"}, rgb_o, bg);
        chk({pre, ".line_start"}, ls_o, e_ls);
        chk({pre, ".frame_start"}, fs_o, e_fs);
        chk({pre, ".frame_cnt"}, fc_o, (pix / fl) % (64'd1 << fw));
    endtask

    // One clock: model steps on the edge with the inputs that were driven, outputs compared 1ns later.
    task automatic step_and_check();
        @(posedge pclk);
        if (rst) begin
            pix    = 0;
            exp_ls = 1'b0;
        end else if (en) begin
            pix    = pix + 1;
            exp_ls = 1'b1;
        end else begin
            exp_ls = 1'b0;
        end
        exp_fs = exp_ls;
        #1;
        check_inst("A", 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, 2, 'h88F,
                   if_a.hcount_out, if_a.vcount_out, if_a.hs_out, if_a.vs_out,
                   if_a.hblnk_out, if_a.vblnk_out, if_a.rgb_out,
                   if_a.line_start, if_a.frame_start, if_a.frame_cnt);
        check_inst("B", 10, 2, 3, 1, 3, 1, 2, 2, 1'b1, 1'b0, 3, 'h3C5,
                   if_b.hcount_out, if_b.vcount_out, if_b.hs_out, if_b.vs_out,
                   if_b.hblnk_out, if_b.vblnk_out, if_b.rgb_out,
                   if_b.line_start, if_b.frame_start, if_b.frame_cnt);
        if (if_a.line_start) ls_seen_a++;
        @(negedge pclk);
    endtask

    initial begin
        longint pix_hold;

        // rgb is constant even while reset is asserted.
        #1;
        chk("A.rgb_in_reset", if_a.rgb_out, 'h88F);
        chk("B.rgb_in_reset", if_b.rgb_out, 'h3C5);

        rst = 1'b1; en = 1'b1;
        repeat (3) step_and_check();

        // Continuous enable: covers several frames of A (84 cycles) and the 3-bit wrap of B (128 cycles/frame).
        rst = 1'b0; en = 1'b1;
        repeat (1100) step_and_check();

        // Every-other-cycle enable: each line_start must be a single pclk wide.
        ls_seen_a = 0;
        for (int i = 0; i < 240; i++) begin
            en = i[0];
            step_and_check();
        end
        chk("A.line_start_count_half_rate", ls_seen_a, 10);

        // Hold en low for 100 cycles mid-line; the model position must not move.
        en = 1'b1;
        repeat (5) step_and_check();
        pix_hold = pix;
        en = 1'b0;
        repeat (100) step_and_check();
        chk("hold_position", pix, pix_hold);
        en = 1'b1;
        repeat (20) step_and_check();

        // Reset mid-frame with en high: rst wins, then counting resumes from 1.
        rst = 1'b1; en = 1'b1;
        step_and_check();
        rst = 1'b0;
        repeat (3) step_and_check();

        // Randomised en with occasional reset.
        for (int i = 0; i < 2500; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step_and_check();
        end

        rst = 1'b0; en = 1'b1;
        repeat (200) step_and_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, expected finish before 1000000");
        $fatal(1);
    end
endmodule
